// File: rtl/uart_pkg.sv
// Shared UART definitions for uart_rx and the future uart_tx.
// Defining UART_RX_PARITY_EN adds the PARITY state to the FSM encoding.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous line that idles high.
`timescale 1ns/1ps
module uart_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames with a valid/ready output register and frame-error/overrun pulses.
// Defining UART_RX_PARITY_EN inserts an even-parity bit between bit 7 and the stop bit.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 1_000_000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              frame_err_o,
  output logic              overrun_o
);

  localparam int CPB   = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = $clog2(CPB);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  if (CPB < 4) begin : g_cpb_check
    $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  logic              w_rx;
  logic              w_tick;
  logic              w_frame_ok;
  uart_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_shift;

  uart_sync u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (w_rx)
  );

  assign w_tick = (r_cnt == CNT_LAST);

`ifdef UART_RX_PARITY_EN
  logic r_par_err;
  assign w_frame_ok = w_rx && !r_par_err;
`else
  assign w_frame_ok = w_rx;
`endif

  // Data bits arrive LSB first, so shift in from the top.
  always_ff @(posedge clk_i) begin
    if (r_state == DATA && w_tick) begin
      r_shift <= {w_rx, r_shift[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err   <= 1'b0;
`endif
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (!w_rx) begin
            r_state <= START;
          end
        end
        START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt   <= '0;
            r_state <= w_rx ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_cnt <= '0;
            r_idx <= r_idx + 1'b1;
            if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_cnt     <= '0;
            r_par_err <= (w_rx != ^r_shift);
            r_state   <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          // Returning to IDLE on the sample leaves half a stop bit to catch the next start edge.
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            if (!w_frame_ok) begin
              frame_err_o <= 1'b1;
            end else if (valid_o && !ready_i) begin
              overrun_o <= 1'b1;
            end else begin
              data_o  <= r_shift;
              valid_o <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
